cnt_snapshot_reader: RTL and testbench
======================================

// Module: cnt_snapshot_reader
// PURPOSE
//  Read-side companion of the writable 8-bit counter: samples the counter output data_cnt,
//  buffers snapshots in a small FIFO, returns them over a rd/rvalid read handshake.
//  Capture is an explicit strobe or automatic on value change.
//  Sits between counter and host; host drains snapshots at its own rate.
// PARAMETERS
//  DW     8  width of data_cnt / rdata
//  DEPTH  4  snapshot FIFO depth, power of 2, >= 2
//  AW     2  log2(DEPTH); pointer width (level is AW+1 bits)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  reset     in   1      asynchronous, active-low reset (0 = reset)
//  data_cnt  in   DW     counter value to sample
//  capture   in   1      1-cycle strobe: push data_cnt this cycle
//  auto_en   in   1      1 = also push whenever data_cnt != last pushed value
//  rd        in   1      pop request
//  clr_ovf   in   1      clears overflow flag
//  rdata     out  DW     popped snapshot, valid while rvalid=1
//  rvalid    out  1      1-cycle pulse, cycle after accepted rd
//  empty     out  1      FIFO empty
//  full      out  1      FIFO full
//  level     out  AW+1   entries held, 0..DEPTH
//  overflow  out  1      sticky: push attempted while full and no pop
// BEHAVIOUR
//  Reset (reset=0, async assert, sync-to-clk release): rdata=0, rvalid=0, empty=1, full=0,
//   level=0, overflow=0, pointers=0, last_val=0, last_vld=0. Reset mid-op discards all entries.
//  push_req = capture | (auto_en & (~last_vld | data_cnt != last_val)); at most one push/cycle.
//  On accepted push: mem[wp]<=data_cnt, wp<=wp+1 (wraps DEPTH-1->0), last_val<=data_cnt, last_vld<=1.
//  pop_ok = rd & ~empty. On pop: rdata<=mem[rp], rp<=rp+1 (wraps), rvalid=1 next cycle only.
//  rd while empty: ignored; rvalid=0, rdata holds previous value. No error flag.
//  Latency: push -> visible in level/empty next cycle; rd -> rdata/rvalid exactly 1 cycle later.
//  No bypass: push and rd in same cycle on empty FIFO -> push only, rd ignored.
//  Full and push_req and pop_ok same cycle: both performed, level unchanged, full stays 1.
//  Full and push_req, no pop: data dropped, pointers/last_val unchanged, overflow<=1.
//  Overflow set and clr_ovf same cycle: set wins (overflow=1).
//  level: +1 push only, -1 pop only, unchanged both/neither; empty=(level==0), full=(level==DEPTH).
//  Registered flags; never underflow below 0 or exceed DEPTH.
//  Back-to-back rd on consecutive cycles drains one entry per cycle, rvalid held high.
//  auto_en: first sample after reset always pushes (last_vld=0); a dropped push does not
//   update last_val, so the same value retries every cycle until space or change.
// STRUCTURE
//  Shared package cnt_pkg: CNT_DW=8, SNAP_DEPTH=4 constants; no typedefs needed.
//  One sub-module: snap_fifo (mem, wp/rp, level, full/empty, registered read port).
//  Top holds change detector (last_val/last_vld), push_req logic, overflow flag.
// TESTING
//  1 Reset: reset=0 mid-stream with level=3 -> all outputs 0, empty=1 immediately (async).
//  2 capture with data_cnt=8'h55, then rd next cycle -> rdata=8'h55, rvalid=1 one cycle later.
//  3 Four captures 8'h10..8'h13 then fifth 8'h14 -> full=1, overflow=1, reads return 10,11,12,13, empty=1.
//  4 full + capture(8'hAA) + rd same cycle -> rdata=oldest, level stays 4, last entry 8'hAA, overflow=0.
//  5 auto_en=1, data_cnt 8'h05,05,06,06,07 one per cycle -> exactly 3 pushes (05,06,07), level=3.
//  6 rd on empty -> rvalid=0, rdata unchanged; capture+rd on empty -> level=1, rvalid=0.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants for the counter snapshot reader.
//   CNT_DW      width of the counter value / snapshot data
//   SNAP_DEPTH  number of snapshot FIFO entries (power of 2, >= 2)
package cnt_pkg;

    localparam int CNT_DW     = 8;
    localparam int SNAP_DEPTH = 4;

endpackage : cnt_pkg

// File: rtl/snap_fifo.sv
// Snapshot FIFO with a registered read port.
//   clk, reset   clock / asynchronous active-low reset
//   push_req     write request (wdata), may be refused when full
//   rd           pop request, ignored while empty
//   wdata        data written on an accepted push
//   push_acc     1 when this cycle's push_req is accepted
//   push_drop    1 when push_req is refused (full, no pop this cycle)
//   rdata        popped entry, registered, holds between pops
//   rvalid       1-cycle pulse, cycle after an accepted rd
//   empty, full  registered flags derived from level
//   level        entries held, 0..DEPTH
//
// Read handshake: rd is a request with no ready/backpressure; it is
// accepted exactly when the FIFO is not empty at that edge. An accepted
// rd produces rvalid=1 with rdata on the next cycle only. rdata is not
// touched by refused reads. There is no write-to-read bypass: an entry
// pushed this cycle can be popped at the earliest next cycle.
module snap_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_req,
    input  logic          rd,
    input  logic [DW-1:0] wdata,
    output logic          push_acc,
    output logic          push_drop,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          pop_ok;
    logic [AW:0]   level_nxt;

    // A push into a full FIFO is still accepted if a pop frees a slot
    // in the same cycle.
    assign pop_ok    = rd & ~empty;
    assign push_acc  = push_req & (~full | pop_ok);
    assign push_drop = push_req & full & ~pop_ok;

    always_comb begin
        level_nxt = level;
        case ({push_acc, pop_ok})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp     <= '0;
            rp     <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (push_acc) wp <= wp + 1'b1;
            if (pop_ok) begin
                rp    <= rp + 1'b1;
                rdata <= mem[rp];
            end
            rvalid <= pop_ok;
            level  <= level_nxt;
            empty  <= (level_nxt == '0);
            full   <= (level_nxt == FULL_LVL);
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wp] <= wdata;
    end

endmodule : snap_fifo

// File: rtl/cnt_snapshot_reader.sv
// Read-side companion of the writable counter: samples data_cnt on an
// explicit strobe or automatically on value change, buffers snapshots in
// a small FIFO and returns them over a rd/rvalid handshake.
//   clk       system clock
//   reset     asynchronous active-low reset
//   data_cnt  counter value to sample
//   capture   1-cycle strobe: push data_cnt this cycle
//   auto_en   also push whenever data_cnt differs from the last pushed value
//   rd        pop request (accepted when not empty)
//   clr_ovf   clears the overflow flag (a same-cycle set wins)
//   rdata     popped snapshot, valid while rvalid=1
//   rvalid    1-cycle pulse, cycle after an accepted rd
//   empty     FIFO empty
//   full      FIFO full
//   level     entries held, 0..DEPTH
//   overflow  sticky: push attempted while full and no pop
module cnt_snapshot_reader
    import cnt_pkg::*;
#(
    parameter int DW    = CNT_DW,
    parameter int DEPTH = SNAP_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data_cnt,
    input  logic          capture,
    input  logic          auto_en,
    input  logic          rd,
    input  logic          clr_ovf,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow
);

    logic [DW-1:0] last_val;
    logic          last_vld;
    logic          push_req;
    logic          push_acc;
    logic          push_drop;

    // last_vld=0 forces the first auto sample after reset to push. Only
    // accepted pushes update last_val, so a dropped value keeps retrying.
    assign push_req = capture | (auto_en & (~last_vld | (data_cnt != last_val)));

    snap_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_req  (push_req),
        .rd        (rd),
        .wdata     (data_cnt),
        .push_acc  (push_acc),
        .push_drop (push_drop),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_val <= '0;
            last_vld <= 1'b0;
        end else if (push_acc) begin
            last_val <= data_cnt;
            last_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule : cnt_snapshot_reader

// File: tb/tb_cnt_snapshot_reader.sv
// Self-checking bench for cnt_snapshot_reader: directed steps followed by
// a random phase, all compared against a queue-based reference model.
module tb_cnt_snapshot_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_cnt;
    logic          capture;
    logic          auto_en;
    logic          rd;
    logic          clr_ovf;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;

    always #5 clk = ~clk;

    cnt_snapshot_reader #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_cnt (data_cnt),
        .capture  (capture),
        .auto_en  (auto_en),
        .rd       (rd),
        .clr_ovf  (clr_ovf),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_ovf;
    logic [DW-1:0] m_last;
    logic          m_lvld;
    int            checks = 0;
    int            errors = 0;

    task automatic model_reset();
        exp_q.delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_last   = '0;
        m_lvld   = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using pre-edge state.
    task automatic model_step(input logic cap, input logic aut, input logic r,
                              input logic clr, input logic [DW-1:0] d);
        bit want_push, can_pop, was_full, dropped;
        want_push = cap || (aut && (!m_lvld || d != m_last));
        can_pop   = r && (exp_q.size() > 0);
        was_full  = (exp_q.size() == DEPTH);
        dropped   = 1'b0;
        m_rvalid  = can_pop;
        if (can_pop) m_rdata = exp_q.pop_front();
        if (want_push) begin
            if (!was_full || can_pop) begin
                exp_q.push_back(d);
                m_last = d;
                m_lvld = 1'b1;
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rvalid"},   32'(rvalid),   32'(m_rvalid));
        chk({tag, ".rdata"},    32'(rdata),    32'(m_rdata));
        chk({tag, ".level"},    32'(level),    32'(exp_q.size()));
        chk({tag, ".empty"},    32'(empty),    32'(exp_q.size() == 0));
        chk({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic cap, input logic aut, input logic r,
                         input logic clr, input logic [DW-1:0] d, input string tag);
        capture  = cap;
        auto_en  = aut;
        rd       = r;
        clr_ovf  = clr;
        data_cnt = d;
        model_step(cap, aut, r, clr, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        capture  = 1'b0;
        auto_en  = 1'b0;
        rd       = 1'b0;
        clr_ovf  = 1'b0;
        data_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // capture then read next cycle
        cycle(1, 0, 0, 0, 8'h55, "t2_cap");
        cycle(0, 0, 1, 0, 8'h00, "t2_rd");
        chk("t2_rdata", 32'(rdata), 32'h55);
        chk("t2_rvalid", 32'(rvalid), 32'h1);
        cycle(0, 0, 0, 0, 8'h00, "t2_after");
        chk("t2_rvalid_pulse", 32'(rvalid), 32'h0);

        // fill, overflow, drain
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'(8'h10 + i), "t3_fill");
        chk("t3_full", 32'(full), 32'h1);
        chk("t3_ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 8'h00, "t3_drain");
            chk("t3_data", 32'(rdata), 32'(8'h10 + i));
        end
        cycle(0, 0, 0, 1, 8'h00, "t3_clr");
        chk("t3_empty", 32'(empty), 32'h1);
        chk("t3_ovf_clr", 32'(overflow), 32'h0);

        // full + push + pop in the same cycle
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'(8'h20 + i), "t4_fill");
        cycle(1, 0, 1, 0, 8'hAA, "t4_both");
        chk("t4_oldest", 32'(rdata), 32'h20);
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 8'h00, "t4_drain");
        chk("t4_last", 32'(rdata), 32'hAA);

        // auto capture on change
        cycle(0, 1, 0, 0, 8'h05, "t5_a");
        cycle(0, 1, 0, 0, 8'h05, "t5_b");
        cycle(0, 1, 0, 0, 8'h06, "t5_c");
        cycle(0, 1, 0, 0, 8'h06, "t5_d");
        cycle(0, 1, 0, 0, 8'h07, "t5_e");
        chk("t5_level", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 8'h00, "t5_drain");
            chk("t5_data", 32'(rdata), 32'(8'h05 + i));
        end

        // rd on empty, then capture+rd on empty (no bypass)
        cycle(0, 0, 1, 0, 8'h00, "t6_rd_empty");
        chk("t6_rvalid", 32'(rvalid), 32'h0);
        chk("t6_rdata_hold", 32'(rdata), 32'h07);
        cycle(1, 0, 1, 0, 8'h3C, "t6_cap_rd");
        chk("t6_level", 32'(level), 32'd1);
        chk("t6_rvalid2", 32'(rvalid), 32'h0);
        cycle(0, 0, 1, 0, 8'h00, "t6_pop");

        // asynchronous reset mid-stream with level=3
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'(8'h40 + i), "t1_fill");
        chk("t1_level3", 32'(level), 32'd3);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t1_async");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // random phase, small data range so repeats and changes both occur
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  8'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cnt_snapshot_reader
